spc_fader: RTL and testbench



---
 rtl/spc_audio_pkg.sv | 20 ++
 rtl/fader_mul.sv | 48 ++++
 rtl/spc_fader.sv | 136 +++++++++++++
 tb/tb_spc_fader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/spc_audio_pkg.sv
// Shared types and constants for the SPC audio output path.
// Build option: SPC_FADER_RAMP_IN_EN adds the RAMP state (1 ms fade-in at song start).
package spc_audio_pkg;

    localparam int         SAMPLE_W   = 16;
    localparam logic [8:0] GAIN_UNITY = 9'd256;
    localparam logic [8:0] RAMP_STEP  = 9'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAY,
        ST_FADE,
        ST_DONE
`ifdef SPC_FADER_RAMP_IN_EN
        ,
        ST_RAMP
`endif
    } fader_state_e;

endpackage

// File: rtl/fader_mul.sv
// One channel of the fader: registers sample and gain, then registers
// (sample * gain) >>> 8 truncated to SAMPLE_W bits. Result holds between strobes.
module fader_mul
    import spc_audio_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en1_i,
    input  logic                       en2_i,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic [8:0]                 gain_i,
    output logic signed [SAMPLE_W-1:0] result_o
);

    localparam int PROD_W = SAMPLE_W + 10;

    logic signed [SAMPLE_W-1:0] sample_q;
    logic [8:0]                 gain_q;
    logic signed [PROD_W-1:0]   sample_x;
    logic signed [PROD_W-1:0]   gain_x;
    logic signed [SAMPLE_W-1:0] result_d;
    logic signed [SAMPLE_W-1:0] result_q;

    // Gain is unsigned, so it is zero-extended before the signed multiply.
    assign sample_x = {{(PROD_W-SAMPLE_W){sample_q[SAMPLE_W-1]}}, sample_q};
    assign gain_x   = {{(PROD_W-9){1'b0}}, gain_q};
    assign result_d = SAMPLE_W'((sample_x * gain_x) >>> 8);

    // NOTE: datapath registers are reset too, because the outputs must read zero during reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q <= '0;
            gain_q   <= '0;
            result_q <= '0;
        end else begin
            if (en1_i) begin
                sample_q <= sample_i;
                gain_q   <= gain_i;
            end
            if (en2_i) begin
                result_q <= result_d;
            end
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/spc_fader.sv
// Per-song output fader: unity gain while playing, linear fade to silence, fade_done.
// Build option: SPC_FADER_RAMP_IN_EN ramps gain 0->256 over 32 samples after start.
module spc_fader
    import spc_audio_pkg::*;
#(
    parameter int FADE_W      = 16,
    parameter int SAMPLE_RATE = 32000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       fade_start,
    input  logic [FADE_W-1:0]          fade_ms,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] in_l,
    input  logic signed [SAMPLE_W-1:0] in_r,
    output logic                       out_valid,
    output logic signed [SAMPLE_W-1:0] out_l,
    output logic signed [SAMPLE_W-1:0] out_r,
    output logic [8:0]                 gain,
    output logic                       fade_done
);

    localparam int PER_W = FADE_W - 3;

    if (SAMPLE_RATE <= 0) begin : g_rate_check
        $error("spc_fader: SAMPLE_RATE must be positive");
    end

    fader_state_e     state_q, state_d;
    logic [8:0]       gain_q, gain_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] fade_period;
    logic             fade_go;
    logic             v1_q, v2_q;

    // fade_ms/8 samples per gain step gives fade_ms milliseconds at 32 kHz.
    assign fade_period = (fade_ms[FADE_W-1:3] == '0) ? PER_W'(1) : fade_ms[FADE_W-1:3];

`ifdef SPC_FADER_RAMP_IN_EN
    assign fade_go = fade_start && (state_q == ST_PLAY || state_q == ST_RAMP);
`else
    assign fade_go = fade_start && (state_q == ST_PLAY);
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        gain_d   = gain_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        if (start) begin
`ifdef SPC_FADER_RAMP_IN_EN
            state_d = ST_RAMP;
            gain_d  = '0;
`else
            state_d = ST_PLAY;
            gain_d  = GAIN_UNITY;
`endif
            cnt_d   = '0;
        end else if (fade_go) begin
            if (fade_ms == '0 || gain_q == '0) begin
                state_d = ST_DONE;
                gain_d  = '0;
            end else begin
                state_d  = ST_FADE;
                period_d = fade_period;
                cnt_d    = '0;
            end
        end else begin
            case (state_q)
`ifdef SPC_FADER_RAMP_IN_EN
                ST_RAMP: if (in_valid) begin
                    gain_d = gain_q + RAMP_STEP;
                    if (gain_d == GAIN_UNITY) state_d = ST_PLAY;
                end
`endif
                ST_FADE: if (in_valid) begin
                    if (cnt_q == period_q - 1'b1) begin
                        cnt_d  = '0;
                        gain_d = gain_q - 1'b1;
                        if (gain_q == 9'd1) state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gain_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            v1_q     <= in_valid;
            v2_q     <= v1_q;
        end
    end

    fader_mul u_mul_l (
        .clk      (clk),
        .reset    (reset),
        .en1_i    (in_valid),
        .en2_i    (v1_q),
        .sample_i (in_l),
        .gain_i   (gain_q),
        .result_o (out_l)
    );

    fader_mul u_mul_r (
        .clk      (clk),
        .reset    (reset),
        .en1_i    (in_valid),
        .en2_i    (v1_q),
        .sample_i (in_r),
        .gain_i   (gain_q),
        .result_o (out_r)
    );

    assign out_valid = v2_q;
    assign gain      = gain_q;
    assign fade_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_spc_fader.sv
// Scoreboard bench for spc_fader; build with +define+SPC_FADER_RAMP_IN_EN for the ramp variant.
module tb_spc_fader;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               fade_start;
    logic [15:0]        fade_ms;
    logic               in_valid;
    logic signed [15:0] in_l;
    logic signed [15:0] in_r;
    logic               out_valid;
    logic signed [15:0] out_l;
    logic signed [15:0] out_r;
    logic [8:0]         gain;
    logic               fade_done;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_l_q[$];
    logic [15:0] exp_r_q[$];

    spc_fader #(.FADE_W(16), .SAMPLE_RATE(32000)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .fade_start (fade_start),
        .fade_ms    (fade_ms),
        .in_valid   (in_valid),
        .in_l       (in_l),
        .in_r       (in_r),
        .out_valid  (out_valid),
        .out_l      (out_l),
        .out_r      (out_r),
        .gain       (gain),
        .fade_done  (fade_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output strobe is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_l_q.size() == 0) begin
                check("unexpected out_valid", 16'(out_valid), 16'd0);
            end else begin
                check("out_l", out_l, exp_l_q.pop_front());
                check("out_r", out_r, exp_r_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r,
                        input logic [15:0] el, input logic [15:0] er);
        in_valid = 1'b1;
        in_l     = l;
        in_r     = r;
        exp_l_q.push_back(el);
        exp_r_q.push_back(er);
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef SPC_FADER_RAMP_IN_EN
        for (int i = 0; i < 32; i++) send(16'h0, 16'h0, 16'h0, 16'h0);
`endif
    endtask

    task automatic begin_fade(input logic [15:0] ms);
        fade_ms    = ms;
        fade_start = 1'b1;
        step();
        fade_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; fade_start = 1'b0; fade_ms = '0;
        in_valid = 1'b0; in_l = '0; in_r = '0;
        #1;
        check("reset gain", 16'(gain), 16'd0);
        check("reset fade_done", 16'(fade_done), 16'd0);
        check("reset out_valid", 16'(out_valid), 16'd0);
        check("reset out_l", out_l, 16'd0);
        step();
        reset = 1'b0;

        // 1: IDLE passes samples at gain 0, two-cycle latency.
        send(16'h4000, 16'h4000, 16'h0000, 16'h0000);
        check("latency t+1", 16'(out_valid), 16'd0);
        step();
        check("latency t+2", 16'(out_valid), 16'd1);
        step();
        check("strobe width", 16'(out_valid), 16'd0);

        // 2: unity gain is exact, including full-scale negative.
        do_start();
        check("play gain", 16'(gain), 16'd256);
        send(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000);
        repeat (2) step();

        // 3: fade_ms=8, period 1: output n = 0x1000*(256-n)/256.
        begin_fade(16'd8);
        check("fade start gain", 16'(gain), 16'd256);
        for (int n = 0; n < 256; n++) begin
            if (n == 128) check("fade mid gain", 16'(gain), 16'd128);
            if (n == 255) begin
                check("fade last gain", 16'(gain), 16'd1);
                check("fade_done early", 16'(fade_done), 16'd0);
            end
            send(16'h1000, 16'hF000, 16'(4096 - 16 * n), 16'(-(4096 - 16 * n)));
        end
        check("fade end gain", 16'(gain), 16'd0);
        check("fade_done", 16'(fade_done), 16'd1);
        repeat (3) step();
        check("done holds", 16'(fade_done), 16'd1);

        // 4: fade_ms=80, period 10; fade_start inside FADE is ignored.
        do_start();
        check("restart fade_done", 16'(fade_done), 16'd0);
        begin_fade(16'd80);
        for (int i = 0; i < 9; i++) send(16'h0, 16'h0, 16'h0, 16'h0);
        check("p10 after 9", 16'(gain), 16'd256);
        send(16'h0, 16'h0, 16'h0, 16'h0);
        check("p10 after 10", 16'(gain), 16'd255);
        begin_fade(16'd8);
        for (int i = 0; i < 9; i++) send(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000);
        check("ignored refade", 16'(gain), 16'd255);
        send(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000);
        check("p10 after 20", 16'(gain), 16'd254);
        do_start();
        begin_fade(16'd0);
        check("zero fade gain", 16'(gain), 16'd0);
        check("zero fade done", 16'(fade_done), 16'd1);
        begin_fade(16'd80);
        check("fade_start in DONE", 16'(fade_done), 16'd1);
        repeat (2) step();

        // 5: start beats fade_start while fading.
        do_start();
        begin_fade(16'd8);
        for (int i = 0; i < 3; i++) send(16'h0, 16'h0, 16'h0, 16'h0);
        check("pre-collision gain", 16'(gain), 16'd253);
        start = 1'b1; fade_start = 1'b1; fade_ms = 16'd8;
        step();
        start = 1'b0; fade_start = 1'b0;
        check("collision fade_done", 16'(fade_done), 16'd0);
`ifdef SPC_FADER_RAMP_IN_EN
        check("collision gain", 16'(gain), 16'd0);
        for (int i = 0; i < 31; i++) send(16'h0, 16'h0, 16'h0, 16'h0);
        check("ramp 31", 16'(gain), 16'd248);
        send(16'h0, 16'h0, 16'h0, 16'h0);
        check("ramp 32", 16'(gain), 16'd256);
`else
        check("collision gain", 16'(gain), 16'd256);
`endif
        begin_fade(16'd8);
        send(16'h0, 16'h0, 16'h0, 16'h0);
        check("play after start", 16'(gain), 16'd255);
        repeat (2) step();

        // 6: asynchronous reset mid-fade with samples in flight.
        in_valid = 1'b1; in_l = 16'h1000; in_r = 16'h1000;
        step();
        in_l = 16'h2000; in_r = 16'h2000;
        step();
        in_valid = 1'b0;
        check("inflight out_l", out_l, 16'h0FF0);
        #1;
        reset = 1'b1;
        #1;
        check("async out_valid", 16'(out_valid), 16'd0);
        check("async out_l", out_l, 16'd0);
        check("async out_r", out_r, 16'd0);
        check("async gain", 16'(gain), 16'd0);
        step();
        step();
        reset = 1'b0;
        repeat (3) step();
        check("idle gain", 16'(gain), 16'd0);
        check("idle fade_done", 16'(fade_done), 16'd0);
        send(16'h4000, 16'h4000, 16'h0000, 16'h0000);
        repeat (3) step();

        check("scoreboard drained", 16'(exp_l_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
